// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} lsu_state_t;
endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rdata_i[{off_i, 3'b000} +: 8];
        h       = rdata_i[{off_i[1], 4'b0000} +: 16];
        load_o  = rdata_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{b[7] & ~uns_i}}, b};
                merge_o = old_i;
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{h[15] & ~uns_i}}, h};
                merge_o = old_i;
                merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-addressed dmem; sub-word
// stores are done as read-modify-write over ACCESS and MERGE.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);
    lsu_state_t  state_q;
    logic        write_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, old_q, rdata_q;
    logic [31:0] load_w, merge_w;
    logic        req_err, in_acc, in_merge, word_st;

    // Upper address bits are range-checked, never truncated into the array.
    assign req_err = (req_size == 2'd3)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                  || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    lsu_lane u_lane (
        .size_i  (size_q),
        .off_i   (addr_q[1:0]),
        .uns_i   (uns_q),
        .rdata_i (mem_readData),
        .wdata_i (wdata_q),
        .old_i   (old_q),
        .load_o  (load_w),
        .merge_o (merge_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    write_q <= req_write;
                    size_q  <= req_size;
                    uns_q   <= req_unsigned;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    err_q   <= req_err;
                    rdata_q <= '0;
                    state_q <= req_err ? S_RESP : S_ACCESS;
                end
                S_ACCESS: begin
                    if (!write_q) begin
                        rdata_q <= load_w;
                        state_q <= S_RESP;
                    end else if (size_q == SZ_WORD) begin
                        state_q <= S_RESP;
                    end else begin
                        old_q   <= mem_readData;
                        state_q <= S_MERGE;
                    end
                end
                S_MERGE: state_q <= S_RESP;
                S_RESP:  if (resp_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes decode only registered state, so reset clears them asynchronously
    // and address/data (from registers) are stable while they are high.
    assign in_acc   = (state_q == S_ACCESS);
    assign in_merge = (state_q == S_MERGE);
    assign word_st  = in_acc && write_q && (size_q == SZ_WORD);

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_rdata    = resp_valid ? rdata_q : '0;
    assign resp_error    = resp_valid && err_q;
    assign mem_memRead   = in_acc && (!write_q || size_q != SZ_WORD);
    assign mem_memWrite  = word_st || in_merge;
    assign mem_address   = (in_acc || in_merge) ? {2'b00, addr_q[31:2]} : '0;
    assign mem_writeData = in_merge ? merge_w : (word_st ? wdata_q : '0);
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, directed plan
// steps, then randomized requests.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_write, req_unsigned, resp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error, mem_memWrite, mem_memRead;
    logic [31:0] resp_rdata, mem_address, mem_writeData, mem_readData;
    logic        fill;
    logic [31:0] dmem [256];
    byte unsigned refm [1024];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData)
    );

    function automatic logic [31:0] seed(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_readData = dmem[mem_address[7:0]];
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 256; i++) dmem[i] <= seed(i);
        else if (mem_memWrite) dmem[mem_address[7:0]] <= mem_writeData;
    end

    function automatic logic [31:0] ref_word(int w);
        return {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request end to end; the model decides error, latency, and data.
    task automatic op(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                      input logic [31:0] d, input int hold, output logic [31:0] got);
        bit          e;
        int          n, lat, elat;
        bit          sawmem;
        logic [31:0] v;
        e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a / 4 >= 256);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 0;
        if (!e && !w) begin
            for (int k = 0; k < n; k++) v = v | (32'(refm[a+k]) << (8*k));
            if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        end
        if (!e && w) for (int k = 0; k < n; k++) refm[a+k] = d[8*k +: 8];
        elat = e ? 1 : (w && n < 4) ? 3 : 2;

        resp_ready = (hold == 0);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk); lat = 1;
        @(negedge clk); req_valid = 1'b0;
        if (!e) chk("mem_address", mem_address, a >> 2);
        sawmem = mem_memRead || mem_memWrite;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); lat++;
            @(negedge clk);
            sawmem = sawmem || mem_memRead || mem_memWrite;
        end
        chk("latency", lat, elat);
        chk("resp_error", resp_error, e);
        chk("resp_rdata", resp_rdata, v);
        if (e) chk("no_mem_access", sawmem, 0);
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, v);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("back_idle", {resp_valid, req_ready}, 2'b01);
        if (!e && w) chk("mem_word", dmem[a >> 2], ref_word(int'(a >> 2)));
    endtask

    initial begin
        logic [31:0] got, wv;
        reset = 1'b1; fill = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 0; req_wdata = 0; resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wv = seed(i);
            for (int k = 0; k < 4; k++) refm[4*i+k] = wv[8*k +: 8];
        end
        @(posedge clk); @(negedge clk);
        fill = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp", {resp_valid, resp_error}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_mem", {mem_memRead, mem_memWrite}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writeData, 0);
        @(negedge clk); reset = 1'b0;

        op(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, got);
        op(0, 2'd2, 0, 32'h10, 0, 0, got);
        chk("lw_const", got, 32'hDEAD_BEEF);
        op(1, 2'd0, 0, 32'h13, 32'h80, 0, got);
        chk("sb_word", dmem[4], 32'h80AD_BEEF);
        op(0, 2'd0, 0, 32'h13, 0, 0, got);
        chk("lb_const", got, 32'hFFFF_FF80);
        op(0, 2'd0, 1, 32'h13, 0, 0, got);
        chk("lbu_const", got, 32'h0000_0080);
        op(1, 2'd1, 0, 32'h12, 32'h1234, 0, got);
        op(0, 2'd1, 0, 32'h12, 0, 0, got);
        chk("lh_const", got, 32'h0000_1234);
        chk("low_half_kept", dmem[4][15:0], 32'h0000_BEEF);
        op(0, 2'd2, 0, 32'h02, 0, 0, got);
        op(0, 2'd1, 0, 32'h01, 0, 0, got);
        op(0, 2'd2, 0, 32'h400, 0, 0, got);
        op(0, 2'd3, 0, 32'h20, 0, 0, got);
        op(0, 2'd2, 0, 32'h10, 0, 3, got);

        // Reset during sb MERGE: outputs clear at once, word untouched.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h55;
        @(posedge clk); @(negedge clk); req_valid = 1'b0;
        @(posedge clk); #1;
        chk("merge_strobe", mem_memWrite, 1);
        reset = 1'b1; #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_resp", {resp_valid, resp_error}, 0);
        chk("midrst_rdata", resp_rdata, 0);
        chk("midrst_mem", {mem_memRead, mem_memWrite}, 0);
        chk("midrst_addr", mem_address, 0);
        chk("midrst_wdata", mem_writeData, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("rmw_abandoned", dmem[8], ref_word(8));
        op(0, 2'd2, 0, 32'h20, 0, 0, got);

        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
               ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, got);
        end
        for (int i = 0; i < 256; i++) chk("final_mem", dmem[i], ref_word(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting directly upstream of the word-addressed data memory (`dmem`). Accepts byte-addressed load/store requests from the execute stage, converts them to word-index accesses, implements byte/halfword stores as read-modify-write sequences, sign/zero-extends loads, and flags misaligned or out-of-range accesses. Presents a valid/ready handshake on both request and response sides.

## Interface
- `MEM_WORDS`, 256: data memory depth in 32-bit words; must match the `dmem` `memorySize` parameter.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and flagged as an error
- `req_unsigned`  in  1  loads only: zero-extend instead of sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer takes response
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_error`  out  1  misaligned, out-of-range, or illegal size
- `mem_address`  out  32  word index to `dmem`
- `mem_writeData`  out  32  word to write
- `mem_memWrite`  out  1  write strobe
- `mem_memRead`  out  1  read enable
- `mem_readData`  in  32  combinational read data from `dmem`

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register op, address, and data.
  - If the request has an error, go straight to RESP with `resp_error` = 1 and make no memory access. Error conditions:
    - half at `addr[0]` = 1
    - word at `addr[1:0]` ≠ 0
    - `req_size` = 3
    - `addr[31:2]` ≥ `MEM_WORDS`
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_address` = `addr[31:2]`.
  - Load: `mem_memRead` = 1; capture `mem_readData` and extract the lane. Little-endian: byte lane = `addr[1:0]`, half lane = `addr[1]`. Sign- or zero-extend into the result register, then go to RESP.
  - sw: `mem_memWrite` = 1, `mem_writeData` = `wdata`, then go to RESP.
  - sb/sh: `mem_memRead` = 1; capture the old word, then go to MERGE.
- MERGE:
  - `mem_memWrite` = 1.
  - `mem_writeData` = old word with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - `mem_address` holds the same value. Go to RESP.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_error` are held stable until `resp_ready`.
  - On `resp_ready`, return to IDLE.
  - No new request is accepted in the same cycle as the handoff.
- Outside the state that needs them:
  - `mem_memRead` = 0, `mem_memWrite` = 0, `mem_writeData` = 0.
  - `mem_address` = 0 in IDLE.
- `mem_memWrite` is registered-state decoded and glitch-free. Address and data are stable for the entire cycle the strobe is high, because `dmem` writes level-sensitively.

## Timing
- Reset values:
  - State = IDLE; `req_ready` = 1.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0.
  - `mem_*` outputs = 0.
- Latency from accept edge to `resp_valid`:
  - Loads and sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
  - Each cycle `resp_ready` is held low adds one cycle.
- Throughput: at most one request per 3 cycles (word ops), or 4 cycles (sub-word stores), with `resp_ready` tied high.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - `mem_memWrite` drops asynchronously.
  - An in-flight RMW is abandoned: the old word is either intact or fully written, never partial.
- Address wrap: `addr[1:0]` selects only the lane; upper bits beyond `MEM_WORDS` raise an error and are never truncated.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_BYTE` / `SZ_HALF` / `SZ_WORD`
  - state enum `lsu_state_t`
- Sub-module `lsu_lane`: combinational extract/extend (load path) and lane merge (store path), keyed by size, `addr[1:0]`, and unsigned flag. The FSM stays in `load_store_unit`.

## Test plan
- sw `0xDEADBEEF` to byte addr `0x10`, then lw from `0x10` → `mem_address` = 4; `resp_rdata` = `0xDEADBEEF`; resp 2 cycles after each accept.
- sb `0x80` at `0x13` over word `0xDEADBEEF` → stored word `0x80ADBEEF`. lb at `0x13` → `0xFFFFFF80`. lbu at `0x13` → `0x00000080`. sb latency is 3 cycles.
- sh `0x1234` at `0x12`, then lh at `0x12` → `0x00001234`. Bytes `0x10`/`0x11` are unchanged.
- lw at `0x02`, lh at `0x01`, and lw at `0x400` (`MEM_WORDS` = 256) → `resp_error` = 1 after 1 cycle; `mem_memRead`/`mem_memWrite` never asserted.
- Hold `resp_ready` low for 3 cycles → `resp_valid`/`resp_rdata` stable and `req_ready` = 0 throughout. Assert reset during sb MERGE → all outputs 0 and state IDLE.
